// File: rtl/hazard_scoreboard_unit.sv
// Load-use hazard scoreboard for the ID stage.
// Tracks in-flight loads and drives stall/flush controls.
module hazard_scoreboard_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic                id_memread,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_rs1_en,
  input  logic                id_rs2_en,
  input  logic                branch_taken,
  input  logic                mem_busy,
  output logic                pc_stall,
  output logic                if_id_stall,
  output logic                stall_mux,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic [LOAD_LAT-1:0] load_pending,
  output logic [CNT_W-1:0]    stall_count
);

  logic [LOAD_LAT-1:0]             vld_q, vld_d;
  logic [LOAD_LAT-1:0][REG_AW-1:0] rd_q, rd_d;
  logic [CNT_W-1:0]                stall_count_q, stall_count_d;
  logic hit, hazard, issue;
  logic sel_frz, sel_flush, sel_stall;

  // Compare each pending load against the enabled ID sources
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (vld_q[i] && !(ZERO_REG && rd_q[i] == '0)) begin
        if (id_rs1_en && rd_q[i] == id_rs1) hit = 1'b1;
        if (id_rs2_en && rd_q[i] == id_rs2) hit = 1'b1;
      end
    end
    hazard    = id_valid & hit;
    sel_frz   = mem_busy;
    sel_flush = !mem_busy & branch_taken;
    sel_stall = !mem_busy & !branch_taken & hazard;
    issue     = id_valid & id_memread & !hazard & !branch_taken
              & !(ZERO_REG && id_rd == '0);
  end

  // Control decode: freeze beats flush beats load-use stall
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    stall_mux   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst_n) begin
      unique case (1'b1)
        sel_frz: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
        end
        sel_flush: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        sel_stall: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          stall_mux   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Advance the load chain and stall counter unless frozen
  always_comb begin
    vld_d         = vld_q;
    rd_d          = rd_q;
    stall_count_d = stall_count_q;
    if (!mem_busy) begin
      for (int i = LOAD_LAT - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        rd_d[i]  = rd_q[i-1];
      end
      vld_d[0] = issue;
      rd_d[0]  = id_rd;
      if (sel_stall && stall_count_q != '1)
        stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q         <= '0;
      rd_q          <= '0;
      stall_count_q <= '0;
    end else begin
      vld_q         <= vld_d;
      rd_q          <= rd_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign load_pending = vld_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Testbench for hazard_scoreboard_unit.
// Three instances: LOAD_LAT=1/CNT_W=2, LOAD_LAT=2, LOAD_LAT=3.
module tb_hazard_scoreboard_unit;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b11100;
  localparam logic [4:0] FRZ   = 5'b11000;
  localparam logic [4:0] FLUSH = 5'b00011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic v = 0, mr = 0, e1 = 0, e2 = 0, br = 0, mb = 0;
  logic [4:0] rd = 0, rs1 = 0, rs2 = 0;

  logic a_pc, a_ifs, a_sm, a_iff, a_exf;
  logic b_pc, b_ifs, b_sm, b_iff, b_exf;
  logic c_pc, c_ifs, c_sm, c_iff, c_exf;
  logic [0:0]  a_lp;
  logic [1:0]  b_lp;
  logic [2:0]  c_lp;
  logic [1:0]  a_cnt;
  logic [15:0] b_cnt, c_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.LOAD_LAT(1), .CNT_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(v), .id_memread(mr),
    .id_rd(rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_en(e1), .id_rs2_en(e2),
    .branch_taken(br), .mem_busy(mb),
    .pc_stall(a_pc), .if_id_stall(a_ifs), .stall_mux(a_sm),
    .if_id_flush(a_iff), .id_ex_flush(a_exf),
    .load_pending(a_lp), .stall_count(a_cnt));

  hazard_scoreboard_unit #(.LOAD_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(v), .id_memread(mr),
    .id_rd(rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_en(e1), .id_rs2_en(e2),
    .branch_taken(br), .mem_busy(mb),
    .pc_stall(b_pc), .if_id_stall(b_ifs), .stall_mux(b_sm),
    .if_id_flush(b_iff), .id_ex_flush(b_exf),
    .load_pending(b_lp), .stall_count(b_cnt));

  hazard_scoreboard_unit #(.LOAD_LAT(3)) u_c (
    .clk(clk), .rst_n(rst_n), .id_valid(v), .id_memread(mr),
    .id_rd(rd), .id_rs1(rs1), .id_rs2(rs2),
    .id_rs1_en(e1), .id_rs2_en(e2),
    .branch_taken(br), .mem_busy(mb),
    .pc_stall(c_pc), .if_id_stall(c_ifs), .stall_mux(c_sm),
    .if_id_flush(c_iff), .id_ex_flush(c_exf),
    .load_pending(c_lp), .stall_count(c_cnt));

  typedef struct {
    string      name;
    int         dut;
    bit         rst;
    logic       v, mr;
    logic [4:0] rd, rs1, rs2;
    logic       e1, e2, br, mb;
    logic [4:0] ctl;
    logic [2:0] lp;
    int         cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(string nm, int d, bit r,
    logic iv, logic imr, int ird, int is1, logic ie1,
    int is2, logic ie2, logic ibr, logic imb,
    logic [4:0] c, logic [2:0] l, int n);
    vec_t t;
    t.name = nm; t.dut = d; t.rst = r;
    t.v = iv; t.mr = imr; t.rd = 5'(ird);
    t.rs1 = 5'(is1); t.e1 = ie1;
    t.rs2 = 5'(is2); t.e2 = ie2;
    t.br = ibr; t.mb = imb;
    t.ctl = c; t.lp = l; t.cnt = n;
    return t;
  endfunction

  task automatic chk(string nm, int d, logic [4:0] c,
                     logic [2:0] l, int n);
    logic [4:0] gc;
    logic [2:0] gl;
    int gn;
    case (d)
      1: begin
        gc = {a_pc, a_ifs, a_sm, a_iff, a_exf};
        gl = {2'b00, a_lp}; gn = int'(a_cnt);
      end
      2: begin
        gc = {b_pc, b_ifs, b_sm, b_iff, b_exf};
        gl = {1'b0, b_lp}; gn = int'(b_cnt);
      end
      default: begin
        gc = {c_pc, c_ifs, c_sm, c_iff, c_exf};
        gl = c_lp; gn = int'(c_cnt);
      end
    endcase
    n_vec++;
    if (gc !== c || gl !== l || gn != n) begin
      n_bad++;
      $display("FAIL %s: got ctl=%b lp=%b cnt=%0d want ctl=%b lp=%b cnt=%0d",
               nm, gc, gl, gn, c, l, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v = 0; mr = 0; e1 = 0; e2 = 0; br = 0; mb = 0;
    rd = 0; rs1 = 0; rs2 = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // LOAD_LAT=1 basic load-use
    tv.push_back(mk("t1_rst",   1,1, 0,0,0,0,0,0,0,0,0, NONE, 0,0));
    tv.push_back(mk("t1_load",  1,0, 1,1,5,0,0,0,0,0,0, NONE, 0,0));
    tv.push_back(mk("t1_stall", 1,0, 1,0,6,5,1,0,0,0,0, STALL,1,0));
    tv.push_back(mk("t1_go",    1,0, 1,0,6,5,1,0,0,0,0, NONE, 0,1));
    tv.push_back(mk("t1_idle",  1,0, 0,0,0,0,0,0,0,0,0, NONE, 0,1));
    // LOAD_LAT=3 back-to-back and one-gap dependents
    tv.push_back(mk("t2_load",  3,1, 1,1,7,0,0,0,0,0,0, NONE, 3'b000,0));
    tv.push_back(mk("t2_s1",    3,0, 1,0,8,0,0,7,1,0,0, STALL,3'b001,0));
    tv.push_back(mk("t2_s2",    3,0, 1,0,8,0,0,7,1,0,0, STALL,3'b010,1));
    tv.push_back(mk("t2_s3",    3,0, 1,0,8,0,0,7,1,0,0, STALL,3'b100,2));
    tv.push_back(mk("t2_go",    3,0, 1,0,8,0,0,7,1,0,0, NONE, 3'b000,3));
    tv.push_back(mk("t2_load2", 3,0, 1,1,7,0,0,0,0,0,0, NONE, 3'b000,3));
    tv.push_back(mk("t2_unrel", 3,0, 1,0,9,1,1,0,0,0,0, NONE, 3'b001,3));
    tv.push_back(mk("t2_g1",    3,0, 1,0,8,7,1,0,0,0,0, STALL,3'b010,3));
    tv.push_back(mk("t2_g2",    3,0, 1,0,8,7,1,0,0,0,0, STALL,3'b100,4));
    tv.push_back(mk("t2_ggo",   3,0, 1,0,8,7,1,0,0,0,0, NONE, 3'b000,5));
    // x0 and source-enable filtering
    tv.push_back(mk("t3_ldx0",  1,1, 1,1,0,0,0,0,0,0,0, NONE, 0,0));
    tv.push_back(mk("t3_rdx0",  1,0, 1,0,4,0,1,0,1,0,0, NONE, 0,0));
    tv.push_back(mk("t3_ldx9",  1,0, 1,1,9,0,0,0,0,0,0, NONE, 0,0));
    tv.push_back(mk("t3_noen",  1,0, 1,0,10,0,0,9,0,0,0, NONE,1,0));
    tv.push_back(mk("t3_ldx9b", 1,0, 1,1,9,0,0,0,0,0,0, NONE, 0,0));
    tv.push_back(mk("t3_en",    1,0, 1,0,10,0,0,9,1,0,0, STALL,1,0));
    tv.push_back(mk("t3_after", 1,0, 0,0,0,0,0,0,0,0,0, NONE, 0,1));
    // Branch beats hazard, flushed load never enters chain
    tv.push_back(mk("t4_load",  3,1, 1,1,4,0,0,0,0,0,0, NONE, 3'b000,0));
    tv.push_back(mk("t4_brhz",  3,0, 1,1,11,4,1,0,0,1,0, FLUSH,3'b001,0));
    tv.push_back(mk("t4_brld",  3,0, 1,1,12,0,0,0,0,1,0, FLUSH,3'b010,0));
    tv.push_back(mk("t4_idle1", 3,0, 0,0,0,0,0,0,0,0,0, NONE, 3'b100,0));
    tv.push_back(mk("t4_idle2", 3,0, 0,0,0,0,0,0,0,0,0, NONE, 3'b000,0));
    // LOAD_LAT=2 memory freeze
    tv.push_back(mk("t5_load",  2,1, 1,1,3,0,0,0,0,0,0, NONE, 3'b000,0));
    tv.push_back(mk("t5_frz1",  2,0, 1,0,8,3,1,0,0,0,1, FRZ,  3'b001,0));
    tv.push_back(mk("t5_frz2",  2,0, 1,0,8,3,1,0,0,1,1, FRZ,  3'b001,0));
    tv.push_back(mk("t5_s1",    2,0, 1,0,8,3,1,0,0,0,0, STALL,3'b001,0));
    tv.push_back(mk("t5_s2",    2,0, 1,0,8,3,1,0,0,0,0, STALL,3'b010,1));
    tv.push_back(mk("t5_go",    2,0, 1,0,8,3,1,0,0,0,0, NONE, 3'b000,2));
    // CNT_W=2 saturation
    tv.push_back(mk("t6_l1",    1,1, 1,1,5,0,0,0,0,0,0, NONE, 0,0));
    tv.push_back(mk("t6_d1",    1,0, 1,0,6,5,1,0,0,0,0, STALL,1,0));
    tv.push_back(mk("t6_l2",    1,0, 1,1,5,0,0,0,0,0,0, NONE, 0,1));
    tv.push_back(mk("t6_d2",    1,0, 1,0,6,5,1,0,0,0,0, STALL,1,1));
    tv.push_back(mk("t6_l3",    1,0, 1,1,5,0,0,0,0,0,0, NONE, 0,2));
    tv.push_back(mk("t6_d3",    1,0, 1,0,6,5,1,0,0,0,0, STALL,1,2));
    tv.push_back(mk("t6_l4",    1,0, 1,1,5,0,0,0,0,0,0, NONE, 0,3));
    tv.push_back(mk("t6_d4",    1,0, 1,0,6,5,1,0,0,0,0, STALL,1,3));
    tv.push_back(mk("t6_sat",   1,0, 0,0,0,0,0,0,0,0,0, NONE, 0,3));

    foreach (tv[k]) begin
      if (tv[k].rst) do_reset();
      v = tv[k].v; mr = tv[k].mr; rd = tv[k].rd;
      rs1 = tv[k].rs1; e1 = tv[k].e1;
      rs2 = tv[k].rs2; e2 = tv[k].e2;
      br = tv[k].br; mb = tv[k].mb;
      @(negedge clk);
      chk(tv[k].name, tv[k].dut, tv[k].ctl, tv[k].lp, tv[k].cnt);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a stall
    do_reset();
    v = 1; mr = 1; rd = 5; e1 = 0; e2 = 0;
    @(negedge clk);
    chk("mr_load", 1, NONE, 3'b000, 0);
    @(posedge clk);
    #1 v = 1; mr = 0; rd = 6; rs1 = 5; e1 = 1;
    @(negedge clk);
    chk("mr_stall", 1, STALL, 3'b001, 0);
    #1 rst_n = 1'b0;
    #1 chk("mr_async", 1, NONE, 3'b000, 0);
    chk("mr_async_c", 3, NONE, 3'b000, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("mr_release", 1, NONE, 3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised load-use hazard controller for the ID stage of the risc_v_top pipeline.
- Supports loads whose result is forwardable only after LOAD_LAT cycles.
- Tracks in-flight loads in an internal shadow chain (EX, MEM1..MEMn).
- Generates stall, bubble and flush controls for PC, IF/ID and ID/EX.
- Handles a global memory freeze and keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_AW, 5: register address width.
- LOAD_LAT, 1: cycles a load occupies EX+MEM before its result is forwardable; legal range 1..4.
- CNT_W, 16: stall counter width.
- ZERO_REG, 1: when 1, register address 0 never creates a hazard.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_memread  in  1  ID instruction is a load.
- id_rd  in  REG_AW  ID destination register.
- id_rs1  in  REG_AW  ID source 1.
- id_rs2  in  REG_AW  ID source 2.
- id_rs1_en  in  1  source 1 actually read.
- id_rs2_en  in  1  source 2 actually read.
- branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline frozen.
- pc_stall  out  1  hold PC.
- if_id_stall  out  1  hold IF/ID register.
- stall_mux  out  1  insert bubble into ID/EX.
- if_id_flush  out  1  squash IF/ID contents.
- id_ex_flush  out  1  squash ID/EX contents.
- load_pending  out  LOAD_LAT  valid bit per chain stage; bit 0 = EX.
- stall_count  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- State: chain of LOAD_LAT entries {vld, rd}. Entry 0 is the load in EX; entry i is the load in MEMi.
- Reset (rst_n=0, asynchronous):
  - all vld = 0 and stall_count = 0.
  - While rst_n=0, every output is forced to 0.
- Match(i, s): vld[i] & rs_en[s] & (rd[i] == rs[s]) & !(ZERO_REG & rd[i]==0).
- hazard = id_valid & OR of Match over all i and both sources.
- All control outputs are combinational from state and current inputs, in the same cycle. Priority order is mem_busy > branch_taken > hazard:
  - mem_busy=1: pc_stall=1, if_id_stall=1, stall_mux=0, both flushes 0. Chain and counter hold. branch_taken is ignored; the branch unit holds it until the freeze ends.
  - else branch_taken=1: if_id_flush=1, id_ex_flush=1, all stalls 0. The ID instruction is wrong-path, so hazard is ignored.
  - else hazard=1: pc_stall=1, if_id_stall=1, stall_mux=1, flushes 0.
  - else: all outputs 0.
- Chain update on each rising edge with mem_busy=0:
  - entry[i] <= entry[i-1] for i = 1..LOAD_LAT-1. The last entry drops off and is then forwardable.
  - entry[0].vld <= id_valid & id_memread & !hazard & !branch_taken & !(ZERO_REG & id_rd==0).
  - entry[0].rd <= id_rd.
  - A bubble (stall or flush) therefore enters as vld=0.
- Stall duration: a dependent instruction directly behind a load stalls exactly LOAD_LAT cycles. With one unrelated instruction between them it stalls LOAD_LAT-1 cycles. LOAD_LAT=1 reproduces the classic single-cycle load-use stall.
- Multiple pending loads to the same rd are legal. The stall lasts until no entry matches.
- stall_count increments on each edge where the hazard row is active (mem_busy=0, branch_taken=0, hazard=1). It saturates at 2^CNT_W-1 and never wraps.
- load_pending[i] = vld[i], registered state only.
- Reset asserted mid-stall clears the chain immediately. The first cycle after release never stalls unless a new load issues.

Test Plan:
1. LOAD_LAT=1: load x5 in ID issues; next cycle ID reads rs1=5 with rs1_en=1 -> one cycle of pc_stall=if_id_stall=stall_mux=1, then 0; stall_count=1.
2. LOAD_LAT=3: load x7 then dependent rs2=7 -> exactly 3 stall cycles; load_pending goes 001, 010, 100, 000; stall_count=3.
3. Load with rd=0, then reader of x0 -> no stall. Load x9 with reader rs2=9 but rs2_en=0 -> no stall. Same case with rs2_en=1 -> stall.
4. Hazard present with branch_taken=1 in the same cycle -> if_id_flush=id_ex_flush=1, stall outputs 0; next cycle load_pending[0]=0; stall_count unchanged.
5. LOAD_LAT=2, mem_busy=1 for 2 cycles while load x3 is in EX with a dependent in ID -> pc_stall=if_id_stall=1, stall_mux=0, load_pending holds 01, count holds. After release -> 2 hazard stall cycles.
6. CNT_W=2: repeated load-use pairs -> count saturates at 3. Assert rst_n=0 mid-stall -> all outputs 0 asynchronously; load_pending=0 and stall_count=0 after release.
